hdmi_rst_seq: RTL and testbench
===============================

// Module: hdmi_rst_seq
// PURPOSE
//  Downstream consumer of the synchronized reset: sequences HDMI-domain resets after PLL lock.
//  Holds all sub-resets until the TMDS PLL is stably locked, then releases serdes, pixel and
//  control resets in fixed order with programmable gaps. Lock loss or soft reset re-arms it.
//  Sits between the reset synchronizer output and the HDMI tx/timing/encoder blocks.
// PARAMETERS
//  LOCK_FILTER  4    consecutive synchronized pll_locked=1 cycles required (>=1)
//  HOLD_CYCLES  16   cycles spent in HOLD after lock accepted (>=1)
//  STAGE_GAP    8    cycles between successive releases, and from ctrl release to done (>=1)
//  CNT_W        16   width of internal hold/gap counter; must hold max(HOLD_CYCLES,STAGE_GAP)
// PORTS
//  clk           in   1  system clock
//  rst           in   1  synchronous reset, active-high
//  pll_locked    in   1  PLL lock, asynchronous; 2-FF synchronized internally (lock_s)
//  soft_rst      in   1  synchronous level request to re-run the sequence
//  rst_serdes_o  out  1  active-high reset to TMDS serializers
//  rst_pix_o     out  1  active-high reset to pixel/timing logic
//  rst_ctrl_o    out  1  active-high reset to control/encoder logic
//  seq_done_o    out  1  high while in RUN
//  lock_lost_o   out  1  one-cycle pulse when lock loss aborts a non-WAIT_LOCK state
//  state_o       out  3  current state encoding (debug)
// BEHAVIOUR
//  - Reset is synchronous, active-high. On rst: state=WAIT_LOCK(0), rst_*_o=1, seq_done_o=0,
//    lock_lost_o=0, sync FFs=0, filt_cnt=0, cnt=0. rst dominates all other inputs.
//  - All outputs registered, updated on the same edge as the state register.
//  - lock_s = pll_locked after 2 FFs. filt_cnt: cleared on any edge with lock_s=0, else +1,
//    saturating at LOCK_FILTER. lock_ok = lock_s && (filt_cnt==LOCK_FILTER).
//  - States (state_o): WAIT_LOCK=0, HOLD=1, REL_SERDES=2, REL_PIX=3, REL_CTRL=4, RUN=5.
//  - WAIT_LOCK: all rst_*_o=1. -> HOLD when lock_ok && !soft_rst; cnt cleared.
//  - HOLD: all rst_*_o=1; stays exactly HOLD_CYCLES cycles -> REL_SERDES (rst_serdes_o->0).
//  - REL_SERDES: STAGE_GAP cycles -> REL_PIX (rst_pix_o->0).
//  - REL_PIX: STAGE_GAP cycles -> REL_CTRL (rst_ctrl_o->0).
//  - REL_CTRL: STAGE_GAP cycles -> RUN (seq_done_o->1). RUN is terminal until abort.
//  - Abort (any state != WAIT_LOCK): if !lock_ok or soft_rst on an edge -> WAIT_LOCK at that
//    edge, all rst_*_o=1, seq_done_o=0, cnt cleared. lock_lost_o=1 for that one cycle only if
//    !lock_ok was a cause (also when soft_rst coincides). soft_rst-only abort: no pulse.
//  - soft_rst held high keeps block in WAIT_LOCK; sequence restarts on first edge it is low
//    with lock_ok. Release order serdes->pix->ctrl is never violated; re-assert is simultaneous.
//  - Latency (defaults, edge 0 = first edge sampling pll_locked=1 from WAIT_LOCK with
//    filt_cnt=0): lock_s=1 after edge 1, HOLD at edge 6, rst_serdes_o=0 after edge 22,
//    rst_pix_o=0 after edge 30, rst_ctrl_o=0 after edge 38, seq_done_o=1 after edge 46.
//    General: serdes release at edge 2+LOCK_FILTER+HOLD_CYCLES.
//  - Lock drop: pll_locked sampled 0 at edge e -> lock_s=0 after e+1 -> WAIT_LOCK after e+2.
//  - Glitch: lock_s low for 1 cycle during WAIT_LOCK/HOLD restarts filtering from 0.
// TESTING
//  1. rst for 3 cycles, pll_locked=0 -> all rst_*_o=1, seq_done_o=0, state_o=0 indefinitely.
//  2. Defaults, pll_locked=1 from edge 0 -> serdes/pix/ctrl release after edges 22/30/38,
//     seq_done_o=1 after edge 46; order and 8-cycle spacing checked exactly.
//  3. In RUN, pll_locked=0 sampled at edge e -> all rst_*_o=1, seq_done_o=0, lock_lost_o=1
//     for exactly one cycle after edge e+2; relock repeats full 46-cycle sequence.
//  4. In REL_PIX, soft_rst=1 for 5 cycles -> WAIT_LOCK same edge, no lock_lost_o pulse;
//     after soft_rst low, rst_serdes_o releases HOLD_CYCLES+1 cycles later (lock_ok steady).
//  5. pll_locked 1-cycle low pulse during HOLD -> filt restarts, HOLD re-entered, serdes
//     release delayed vs case 2 by pulse position; lock_lost_o pulses once.
//  6. rst asserted in REL_CTRL with soft_rst=1 and pll_locked=0 same cycle -> reset values only,
//     lock_lost_o=0.

Source files
------------

// File: rtl/hdmi_rst_seq.sv
// HDMI reset sequencer: waits for a filtered, stable PLL lock, then releases the
// serdes, pixel and control resets in order with programmable gaps.
module hdmi_rst_seq #(
  parameter int LOCK_FILTER = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 8,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       soft_rst,
  output logic       rst_serdes_o,
  output logic       rst_pix_o,
  output logic       rst_ctrl_o,
  output logic       seq_done_o,
  output logic       lock_lost_o,
  output logic [2:0] state_o
);

  localparam int FILT_W = $clog2(LOCK_FILTER + 1);

  typedef enum logic [2:0] {
    WAIT_LOCK  = 3'd0,
    HOLD       = 3'd1,
    REL_SERDES = 3'd2,
    REL_PIX    = 3'd3,
    REL_CTRL   = 3'd4,
    RUN        = 3'd5
  } state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [FILT_W-1:0] filt_cnt;
  logic              sync1, lock_s;
  logic              lock_ok;
  logic              abort;
  logic              serdes_nx, pix_nx, ctrl_nx, done_nx, lost_nx;

  // pll_locked is asynchronous to clk; two flops before anything looks at it.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync1  <= pll_locked;
      lock_s <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      filt_cnt <= '0;
    end else if (!lock_s) begin
      filt_cnt <= '0;
    end else if (filt_cnt != FILT_W'(LOCK_FILTER)) begin
      filt_cnt <= filt_cnt + FILT_W'(1);
    end
  end

  assign lock_ok = lock_s && (filt_cnt == FILT_W'(LOCK_FILTER));
  assign abort   = (state != WAIT_LOCK) && (!lock_ok || soft_rst);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    lost_nx  = 1'b0;
    case (state)
      WAIT_LOCK: begin
        if (lock_ok && !soft_rst) begin
          state_nx = HOLD;
          cnt_nx   = '0;
        end
      end
      HOLD: begin
        if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
          state_nx = REL_SERDES;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      REL_SERDES, REL_PIX, REL_CTRL: begin
        if (cnt == CNT_W'(STAGE_GAP - 1)) begin
          state_nx = (state == REL_SERDES) ? REL_PIX :
                     (state == REL_PIX)    ? REL_CTRL : RUN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      RUN: begin
        cnt_nx = '0;
      end
      default: begin
        state_nx = WAIT_LOCK;
        cnt_nx   = '0;
      end
    endcase
    // Abort overrides any progress; the pulse flags only lock-related aborts.
    if (abort) begin
      state_nx = WAIT_LOCK;
      cnt_nx   = '0;
      lost_nx  = !lock_ok;
    end
  end

  // Outputs decode from the next state so they change on the same edge as state.
  always_comb begin
    serdes_nx = (state_nx == WAIT_LOCK) || (state_nx == HOLD);
    pix_nx    = serdes_nx || (state_nx == REL_SERDES);
    ctrl_nx   = pix_nx || (state_nx == REL_PIX);
    done_nx   = (state_nx == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= WAIT_LOCK;
      cnt          <= '0;
      rst_serdes_o <= 1'b1;
      rst_pix_o    <= 1'b1;
      rst_ctrl_o   <= 1'b1;
      seq_done_o   <= 1'b0;
      lock_lost_o  <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      rst_serdes_o <= serdes_nx;
      rst_pix_o    <= pix_nx;
      rst_ctrl_o   <= ctrl_nx;
      seq_done_o   <= done_nx;
      lock_lost_o  <= lost_nx;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_hdmi_rst_seq.sv
// Bench for hdmi_rst_seq: a time-since-hold model checked every cycle, plus
// directed scenarios with hand-computed edge-accurate expectations.
module tb_hdmi_rst_seq;
  localparam int F = 4;
  localparam int H = 16;
  localparam int G = 8;

  logic       clk = 1'b0;
  logic       rst, pll_locked, soft_rst;
  logic       rst_serdes_o, rst_pix_o, rst_ctrl_o, seq_done_o, lock_lost_o;
  logic [2:0] state_o;

  int total = 0;
  int bad   = 0;
  int ecount;
  bit chk_en = 1'b0;

  // Model: lock pipeline, lock run length, and edges elapsed since HOLD entry.
  bit m_p1 = 1'b0, m_ls = 1'b0, m_lost = 1'b0, m_ok;
  int m_run = 0;
  int m_t = -1;

  hdmi_rst_seq dut (
    .clk(clk), .rst(rst), .pll_locked(pll_locked), .soft_rst(soft_rst),
    .rst_serdes_o(rst_serdes_o), .rst_pix_o(rst_pix_o), .rst_ctrl_o(rst_ctrl_o),
    .seq_done_o(seq_done_o), .lock_lost_o(lock_lost_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, ecount, act, exp);
    end
  endfunction

  function automatic int exp_state(input int t);
    if (t < 0) return 0;
    if (t < H) return 1;
    if (t < H + G) return 2;
    if (t < H + 2 * G) return 3;
    if (t < H + 3 * G) return 4;
    return 5;
  endfunction

  always @(posedge clk) begin
    m_ok = m_ls && (m_run == F);
    if (rst) begin
      m_p1 = 1'b0; m_ls = 1'b0; m_run = 0; m_t = -1; m_lost = 1'b0;
    end else begin
      if (m_t < 0) begin
        if (m_ok && !soft_rst) m_t = 0;
        m_lost = 1'b0;
      end else if (!m_ok || soft_rst) begin
        m_t = -1;
        m_lost = !m_ok;
      end else begin
        if (m_t < H + 3 * G) m_t++;
        m_lost = 1'b0;
      end
      m_run = m_ls ? ((m_run < F) ? m_run + 1 : F) : 0;
      m_ls = m_p1;
      m_p1 = pll_locked;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_serdes", 8'(rst_serdes_o), 8'(m_t < H));
      chk("m_pix",    8'(rst_pix_o),    8'(m_t < H + G));
      chk("m_ctrl",   8'(rst_ctrl_o),   8'(m_t < H + 2 * G));
      chk("m_done",   8'(seq_done_o),   8'(m_t >= H + 3 * G));
      chk("m_lost",   8'(lock_lost_o),  8'(m_lost));
      chk("m_state",  8'(state_o),      8'(exp_state(m_t)));
    end
  end

  task automatic tick();
    @(posedge clk);
    ecount++;
    #1;
  endtask

  task automatic wait_edge(input int k);
    while (ecount < k) tick();
  endtask

  initial begin
    rst = 1'b1; pll_locked = 1'b0; soft_rst = 1'b0; ecount = -100;
    // Case 1: reset, no lock.
    tick(); chk_en = 1'b1;
    tick(); tick();
    chk("rst_state", 8'(state_o), 8'd0);
    chk("rst_serdes", 8'(rst_serdes_o), 8'd1);
    chk("rst_done", 8'(seq_done_o), 8'd0);
    rst = 1'b0;
    repeat (20) tick();
    chk("nolock_state", 8'(state_o), 8'd0);
    chk("nolock_ctrl", 8'(rst_ctrl_o), 8'd1);

    // Case 2: lock from edge 0.
    pll_locked = 1'b1; ecount = -1;
    wait_edge(5);  chk("c2_e5_state", 8'(state_o), 8'd0);
    wait_edge(6);  chk("c2_e6_state", 8'(state_o), 8'd1);
    wait_edge(21); chk("c2_e21_serdes", 8'(rst_serdes_o), 8'd1);
    wait_edge(22); chk("c2_e22_serdes", 8'(rst_serdes_o), 8'd0);
                   chk("c2_e22_pix", 8'(rst_pix_o), 8'd1);
    wait_edge(29); chk("c2_e29_pix", 8'(rst_pix_o), 8'd1);
    wait_edge(30); chk("c2_e30_pix", 8'(rst_pix_o), 8'd0);
                   chk("c2_e30_ctrl", 8'(rst_ctrl_o), 8'd1);
    wait_edge(37); chk("c2_e37_ctrl", 8'(rst_ctrl_o), 8'd1);
    wait_edge(38); chk("c2_e38_ctrl", 8'(rst_ctrl_o), 8'd0);
    wait_edge(45); chk("c2_e45_done", 8'(seq_done_o), 8'd0);
    wait_edge(46); chk("c2_e46_done", 8'(seq_done_o), 8'd1);
                   chk("c2_e46_state", 8'(state_o), 8'd5);

    // Case 3: lock drop sampled at edge 51, relock sampled at edge 55.
    wait_edge(50); pll_locked = 1'b0;
    wait_edge(52); chk("c3_e52_done", 8'(seq_done_o), 8'd1);
                   chk("c3_e52_lost", 8'(lock_lost_o), 8'd0);
    wait_edge(53); chk("c3_e53_lost", 8'(lock_lost_o), 8'd1);
                   chk("c3_e53_serdes", 8'(rst_serdes_o), 8'd1);
                   chk("c3_e53_state", 8'(state_o), 8'd0);
    wait_edge(54); chk("c3_e54_lost", 8'(lock_lost_o), 8'd0);
    pll_locked = 1'b1;
    wait_edge(100); chk("c3_e100_done", 8'(seq_done_o), 8'd0);
    wait_edge(101); chk("c3_e101_done", 8'(seq_done_o), 8'd1);

    // Case 4: soft reset restarts from RUN, then again for 5 edges inside REL_PIX.
    wait_edge(104); soft_rst = 1'b1;
    wait_edge(105); chk("c4_e105_state", 8'(state_o), 8'd0);
                    chk("c4_e105_lost", 8'(lock_lost_o), 8'd0);
    soft_rst = 1'b0;
    wait_edge(132); chk("c4_e132_state", 8'(state_o), 8'd3);
    soft_rst = 1'b1;
    wait_edge(133); chk("c4_e133_state", 8'(state_o), 8'd0);
                    chk("c4_e133_lost", 8'(lock_lost_o), 8'd0);
                    chk("c4_e133_serdes", 8'(rst_serdes_o), 8'd1);
    wait_edge(137); soft_rst = 1'b0;
    wait_edge(153); chk("c4_e153_serdes", 8'(rst_serdes_o), 8'd1);
    wait_edge(154); chk("c4_e154_serdes", 8'(rst_serdes_o), 8'd0);

    // Case 5: one-edge lock glitch during HOLD (HOLD entered at 162, glitch at 166).
    wait_edge(160); soft_rst = 1'b1;
    wait_edge(161); soft_rst = 1'b0;
    wait_edge(165); pll_locked = 1'b0;
    wait_edge(166); pll_locked = 1'b1;
    wait_edge(167); chk("c5_e167_state", 8'(state_o), 8'd1);
    wait_edge(168); chk("c5_e168_lost", 8'(lock_lost_o), 8'd1);
                    chk("c5_e168_state", 8'(state_o), 8'd0);
    wait_edge(169); chk("c5_e169_lost", 8'(lock_lost_o), 8'd0);
    wait_edge(172); chk("c5_e172_state", 8'(state_o), 8'd0);
    wait_edge(173); chk("c5_e173_state", 8'(state_o), 8'd1);
    wait_edge(188); chk("c5_e188_serdes", 8'(rst_serdes_o), 8'd1);
    wait_edge(189); chk("c5_e189_serdes", 8'(rst_serdes_o), 8'd0);

    // Case 6: rst together with soft_rst and lock loss while in REL_CTRL.
    wait_edge(207); chk("c6_e207_state", 8'(state_o), 8'd4);
    rst = 1'b1; soft_rst = 1'b1; pll_locked = 1'b0;
    wait_edge(208); chk("c6_e208_state", 8'(state_o), 8'd0);
                    chk("c6_e208_lost", 8'(lock_lost_o), 8'd0);
                    chk("c6_e208_ctrl", 8'(rst_ctrl_o), 8'd1);
                    chk("c6_e208_done", 8'(seq_done_o), 8'd0);
    rst = 1'b0;
    wait_edge(215); chk("c6_e215_state", 8'(state_o), 8'd0);
                    chk("c6_e215_lost", 8'(lock_lost_o), 8'd0);
    soft_rst = 1'b0;
    wait_edge(220);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
